// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: scans a ROWS x COLS keypad matrix by driving one column
// low at a time, debounces press and release on the synchronized row lines,
// and queues one key code per accepted press into a small event FIFO.
// Optional feature macro: KEYPAD_REPEAT_EN -- when defined, a held key pushes
// its code again every REPEAT_CYCLES cycles.
`timescale 1ns/1ps

module keypad_matrix_scan #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 1000000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ROWS-1:0]                 R,
    output logic [COLS-1:0]                 C,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic                            key_held,
    output logic                            overflow,
    input  logic                            ovf_clr
);

    localparam int CODE_W = $clog2(ROWS*COLS);
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int SLOT_W = $clog2(SCAN_CYCLES);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    // Reject configurations outside the supported ranges at elaboration.
    generate
        if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_CYCLES < 4 ||
            DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("keypad_matrix_scan: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } state_t;

    state_t              state_reg;
    logic [ROWS-1:0]     sync1_reg;
    logic [ROWS-1:0]     rs_reg;
    logic [COL_W-1:0]    col_reg;
    logic [SLOT_W-1:0]   slot_reg;
    logic [DB_W-1:0]     db_cnt_reg;
    logic [ROWS-1:0]     pat_reg;
    logic                key_held_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic                overflow_reg;
    logic [CODE_W-1:0]   mem [FIFO_DEPTH];

    // Decoded conditions shared by the FSM and the event path
    logic                rs_idle;
    logic                pat_match;
    logic                slot_last;
    logic                slot_sample;
    logic                db_done;
    logic [COL_W-1:0]    col_inc;
    logic [ROW_W-1:0]    row_idx;
    logic [CODE_W-1:0]   press_code;
    logic                press_accept;
    logic                ev_push_next;
    logic [CODE_W-1:0]   ev_code_next;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop_next;
    logic                push_ok_next;
    logic                drop_next;

    assign rs_idle      = &rs_reg;
    assign pat_match    = (rs_reg == pat_reg);
    assign slot_last    = (slot_reg == SLOT_W'(SCAN_CYCLES - 1));
    // Rows are only trusted late in the slot, once the new column drive has
    // propagated through the matrix and the two synchronizer stages.
    assign slot_sample  = (slot_reg >= SLOT_W'(SCAN_CYCLES - 2));
    assign db_done      = (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1));
    assign col_inc      = (col_reg == COL_W'(COLS - 1)) ? '0 : col_reg + 1'b1;
    assign press_accept = (state_reg == ST_PRESS_DB) && pat_match && db_done;

    // Lowest-numbered low row in the latched pattern wins on multi-key presses
    always_comb begin
        row_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!pat_reg[i]) begin
                row_idx = ROW_W'(i);
            end
        end
    end

    assign press_code = CODE_W'(col_reg) * CODE_W'(ROWS) + CODE_W'(row_idx);

    // Column drive: exactly one active-low column, selected by col_reg
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
            assign C[gi] = (col_reg != COL_W'(gi));
        end
    endgenerate

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0]  rep_cnt_reg;
    logic [CODE_W-1:0] held_code_reg;
    logic              rep_fire;

    // A repeat only fires while the key is still seen pressed in HELD
    assign rep_fire = (state_reg == ST_HELD) && !rs_idle &&
                      (rep_cnt_reg == REP_W'(REPEAT_CYCLES - 1));

    // Repeat timer: restarts at acceptance, runs only while held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_reg   <= '0;
            held_code_reg <= '0;
        end else if (press_accept) begin
            rep_cnt_reg   <= '0;
            held_code_reg <= press_code;
        end else if (state_reg == ST_HELD && !rs_idle) begin
            rep_cnt_reg   <= rep_fire ? '0 : rep_cnt_reg + 1'b1;
        end else begin
            rep_cnt_reg   <= '0;
        end
    end

    // Event source: debounced press, or a repeat of the held code
    always_comb begin
        ev_push_next = 1'b0;
        ev_code_next = press_code;
        if (press_accept) begin
            ev_push_next = 1'b1;
        end else if (rep_fire) begin
            ev_push_next = 1'b1;
            ev_code_next = held_code_reg;
        end
    end
`else
    // Event source: one event per debounced press
    always_comb begin
        ev_push_next = press_accept;
        ev_code_next = press_code;
    end
`endif

    // FIFO status; pointers carry one extra wrap bit to tell full from empty
    assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full    = ((wr_ptr_reg - rd_ptr_reg) == PTR_W'(FIFO_DEPTH));
    assign pop_next     = !fifo_empty && key_ready;
    assign push_ok_next = ev_push_next && (!fifo_full || pop_next);
    assign drop_next    = ev_push_next && fifo_full && !pop_next;

    assign key_valid = !fifo_empty;
    assign key_code  = fifo_empty ? '0 : mem[rd_ptr_reg[ADDR_W-1:0]];
    assign key_held  = key_held_reg;
    assign overflow  = overflow_reg;

    // Two-flop synchronizer for the asynchronous row lines (idle = all ones)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '1;
            rs_reg    <= '1;
        end else begin
            sync1_reg <= R;
            rs_reg    <= sync1_reg;
        end
    end

    // Scan / debounce state machine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_SCAN;
            col_reg      <= '0;
            slot_reg     <= '0;
            db_cnt_reg   <= '0;
            pat_reg      <= '1;
            key_held_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_SCAN: begin
                    if (slot_sample && !rs_idle) begin
                        state_reg  <= ST_PRESS_DB;
                        pat_reg    <= rs_reg;
                        db_cnt_reg <= '0;
                    end else if (slot_last) begin
                        slot_reg <= '0;
                        col_reg  <= col_inc;
                    end else begin
                        slot_reg <= slot_reg + 1'b1;
                    end
                end
                ST_PRESS_DB: begin
                    if (!pat_match) begin
                        // Bounce: give up and rescan this column from slot start
                        state_reg  <= ST_SCAN;
                        slot_reg   <= '0;
                        db_cnt_reg <= '0;
                    end else if (db_done) begin
                        state_reg    <= ST_HELD;
                        key_held_reg <= 1'b1;
                        db_cnt_reg   <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (rs_idle) begin
                        state_reg    <= ST_RELEASE_DB;
                        key_held_reg <= 1'b0;
                        db_cnt_reg   <= '0;
                    end
                end
                ST_RELEASE_DB: begin
                    if (!rs_idle) begin
                        state_reg    <= ST_HELD;
                        key_held_reg <= 1'b1;
                        db_cnt_reg   <= '0;
                    end else if (db_done) begin
                        // Resume scanning at the next column so the released
                        // key is not immediately rescanned
                        state_reg  <= ST_SCAN;
                        col_reg    <= col_inc;
                        slot_reg   <= '0;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_SCAN;
                end
            endcase
        end
    end

    // FIFO pointers and sticky overflow; a drop wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok_next) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_next) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (drop_next) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push_ok_next) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= ev_code_next;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Bench for keypad_matrix_scan: a behavioural keypad matrix drives R from C,
// directed vectors cover single and multi-key presses, then hand-written
// sequences cover bounce, FIFO overflow, reset mid-press and auto-repeat.
`timescale 1ns/1ps

module tb_keypad_matrix_scan;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SCAN  = 16;
    localparam int DB    = 10;
    localparam int DEPTH = 4;
    localparam int REP   = 100;
    // sync (2) + window (2) + debounce + 1, plus one full scan round of misses
    localparam int LAT_BOUND = COLS*SCAN + 2 + 2 + DB + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] R;
    logic [3:0] C;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overflow;
    logic       ovf_clr;

    logic [15:0] key_down;
    int          checks = 0;
    int          errors = 0;
    int          ev_count = 0;
    logic [3:0]  ev_q [$];

    keypad_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DB),
        .FIFO_DEPTH(DEPTH), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .reset(reset), .R(R), .C(C), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        R = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (key_down[c*ROWS + r] && !C[c]) R[r] = 1'b0;
            end
        end
    end

    // Record every accepted handshake
    always @(negedge clk) begin
        if (!reset && key_valid && key_ready) begin
            ev_count++;
            ev_q.push_back(key_code);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input int col, input logic [3:0] rows);
        key_down = '0;
        for (int r = 0; r < ROWS; r++) key_down[col*ROWS + r] = rows[r];
    endtask

    // Wait (bounded) for key_valid; returns edges elapsed; ends at posedge+1
    task automatic wait_valid(output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                cyc = i;
                break;
            end
        end
        #6;
    endtask

    task automatic wait_held(input logic val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_held === val) begin
                ok = 1'b1;
                break;
            end
        end
        #6;
    endtask

    task automatic wait_c_change(input logic [3:0] old_c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (C !== old_c) begin
                ok = 1'b1;
                break;
            end
        end
        #6;
    endtask

    task automatic wait_c_eq(input logic [3:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (C === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int         col;
        logic [3:0] rows;
        logic [3:0] exp_code;
        logic [3:0] exp_c_held;
        logic [3:0] exp_c_next;
    } vec_t;

    vec_t vecs [6];

    typedef struct {
        int         col;
        logic [3:0] rows;
    } key_t;

    key_t       fifo_keys [5];
    logic [3:0] fifo_exp [4];

    initial begin
        int  lat;
        int  n0;
        bit  ok;
        logic [3:0] head;

        vecs[0] = '{1, 4'b0100,  6, 4'b1101, 4'b1011};
        vecs[1] = '{2, 4'b1010,  9, 4'b1011, 4'b0111};
        vecs[2] = '{0, 4'b0001,  0, 4'b1110, 4'b1101};
        vecs[3] = '{3, 4'b1000, 15, 4'b0111, 4'b1110};
        vecs[4] = '{3, 4'b0110, 13, 4'b0111, 4'b1110};
        vecs[5] = '{0, 4'b1100,  2, 4'b1110, 4'b1101};

        fifo_keys[0] = '{0, 4'b0010};
        fifo_keys[1] = '{1, 4'b0001};
        fifo_keys[2] = '{1, 4'b1000};
        fifo_keys[3] = '{2, 4'b0100};
        fifo_keys[4] = '{3, 4'b0010};
        fifo_exp[0] = 4'd1;
        fifo_exp[1] = 4'd4;
        fifo_exp[2] = 4'd7;
        fifo_exp[3] = 4'd10;

        reset     = 1'b1;
        key_ready = 1'b0;
        ovf_clr   = 1'b0;
        key_down  = '0;
        #1;
        check("reset C", C, 4'b1110);
        check("reset key_valid", key_valid, 0);
        check("reset key_code", key_code, 0);
        check("reset key_held", key_held, 0);
        check("reset overflow", overflow, 0);
        step(3);
        reset = 1'b0;
        key_ready = 1'b1;
        step(2);

        // Directed single and multi-key presses
        for (int v = 0; v < 6; v++) begin
            n0 = ev_count;
            set_keys(vecs[v].col, vecs[v].rows);
            wait_valid(lat, ok);
            check($sformatf("v%0d event seen", v), ok, 1);
            check($sformatf("v%0d key_code", v), ev_q.size() > 0 ? ev_q[ev_q.size()-1] : 4'hx, vecs[v].exp_code);
            check($sformatf("v%0d latency<=%0d (lat=%0d)", v, LAT_BOUND, lat), lat <= LAT_BOUND, 1);
            check($sformatf("v%0d C while held", v), C, vecs[v].exp_c_held);
            step(40);
            check($sformatf("v%0d single event", v), ev_count - n0, 1);
            check($sformatf("v%0d key_held", v), key_held, 1);
            key_down = '0;
            wait_c_change(vecs[v].exp_c_held, ok);
            check($sformatf("v%0d C after release", v), C, vecs[v].exp_c_next);
            check($sformatf("v%0d key_held released", v), key_held, 0);
        end

        // Bounce on row 0 / column 0 must not produce an event
        n0 = ev_count;
        for (int i = 0; i < 10; i++) begin
            key_down = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            step(3);
        end
        check("bounce no event", ev_count - n0, 0);
        key_down = 16'h0001;
        wait_valid(lat, ok);
        check("bounce then stable event", ok, 1);
        check("bounce key_code", ev_q.size() > 0 ? ev_q[ev_q.size()-1] : 4'hx, 0);
        step(30);
        check("bounce exactly one event", ev_count - n0, 1);
        key_down = '0;
        wait_c_change(4'b1110, ok);
        check("bounce C after release", C, 4'b1101);

        // FIFO fill with no consumer: four stored, fifth dropped
        key_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_keys(fifo_keys[k].col, fifo_keys[k].rows);
            wait_held(1'b1, ok);
            check($sformatf("fifo press %0d accepted", k), ok, 1);
            key_down = '0;
            wait_held(1'b0, ok);
            step(15);
            if (k == 3) check("fifo full no overflow", overflow, 0);
        end
        check("fifo overflow set", overflow, 1);
        check("fifo key_valid", key_valid, 1);
        head = key_code;
        step(5);
        check("fifo head stable", key_code, head);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fifo pop %0d valid", k), key_valid, 1);
            check($sformatf("fifo pop %0d code", k), key_code, fifo_exp[k]);
            key_ready = 1'b1;
            step(1);
            key_ready = 1'b0;
        end
        check("fifo drained", key_valid, 0);
        check("overflow sticky", overflow, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("overflow cleared", overflow, 0);

        // Reset during PRESS_DB of a column-2 key, with an unread entry queued
        set_keys(0, 4'b0010);
        wait_held(1'b1, ok);
        key_down = '0;
        wait_held(1'b0, ok);
        step(15);
        check("pre-reset key_valid", key_valid, 1);
        set_keys(2, 4'b0001);
        wait_c_eq(4'b1011, ok);
        check("reached column 2", ok, 1);
        step(20);
        check("pre-reset still debouncing", key_held, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async reset C", C, 4'b1110);
        check("async reset key_valid", key_valid, 0);
        check("async reset key_held", key_held, 0);
        step(3);
        reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (key_valid) ok = 1'b1;
        end
        #6;
        check("no early event after reset", ok, 0);
        wait_valid(lat, ok);
        check("re-debounced event", ok, 1);
        check("re-debounced key_code", key_code, 8);
        key_down = '0;
        wait_held(1'b0, ok);
        step(15);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        check("re-debounced popped", key_valid, 0);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat: initial event plus one per REP cycles while held
        key_ready = 1'b1;
        n0 = ev_count;
        set_keys(1, 4'b0010);
        wait_valid(lat, ok);
        check("repeat initial event", ok, 1);
        step(350);
        check("repeat event count", ev_count - n0, 4);
        for (int i = n0; i < ev_count; i++) begin
            check($sformatf("repeat code %0d", i - n0), ev_q[i], 5);
        end
        key_down = '0;
        wait_held(1'b0, ok);
        step(15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scan.md
KEYPAD_MATRIX_SCAN -- requirements
Module: keypad_matrix_scan

Interface
REQ-001 Parameter ROWS, 4, number of row inputs (2..8).
REQ-002 Parameter COLS, 4, number of column drive outputs (2..8).
REQ-003 Parameter SCAN_CYCLES, 16, clk cycles each column is driven while scanning (>=4).
REQ-004 Parameter DEBOUNCE_CYCLES, 10, consecutive stable clk cycles required to accept press or release (>=1).
REQ-005 Parameter FIFO_DEPTH, 4, key-event FIFO entries (power of 2, >=2).
REQ-006 Parameter REPEAT_CYCLES, 1000000, auto-repeat period; used only with KEYPAD_REPEAT_EN.
REQ-007 clk  input  1  single clock for all logic.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 R  input  ROWS  row lines, active-low (pulled up), asynchronous to clk.
REQ-010 C  output  COLS  column drives, active-low, one-hot-low.
REQ-011 key_code  output  $clog2(ROWS*COLS)  code at FIFO head.
REQ-012 key_valid  output  1  FIFO non-empty.
REQ-013 key_ready  input  1  consumer pop; pop occurs when key_valid && key_ready.
REQ-014 key_held  output  1  high in HELD state.
REQ-015 overflow  output  1  sticky; event dropped because FIFO full.
REQ-016 ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-017 R SHALL pass through a 2-flop synchronizer (reset value all ones); all decisions SHALL use the synchronized value rs.
REQ-018 Exactly one C bit SHALL be low at all times after reset; column index col advances 0..COLS-1 and wraps to 0.
REQ-019 FSM states SHALL be SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-020 SCAN: col advances every SCAN_CYCLES cycles; rs sampled only in the last 2 cycles of each column slot; any rs bit low -> PRESS_DB, col frozen, pattern latched.
REQ-021 PRESS_DB: counter counts cycles with rs equal to latched pattern; any mismatch -> SCAN (same col, slot timer restarted); reaching DEBOUNCE_CYCLES -> HELD and one event push.
REQ-022 Key code SHALL equal col*ROWS + index of lowest-numbered low row bit in the latched pattern.
REQ-023 HELD: col frozen; rs all ones -> RELEASE_DB.
REQ-024 RELEASE_DB: rs all ones for DEBOUNCE_CYCLES -> SCAN with col advanced by one (wrap); any low bit -> HELD, counter cleared.
REQ-025 Press-to-key_valid latency SHALL be at most 2 (sync) + 2 + DEBOUNCE_CYCLES + 1 cycles from the sampling edge.
REQ-026 FIFO: push when event generated and not full; pop on key_valid && key_ready; simultaneous push and pop when full SHALL succeed for both; when empty, push takes effect and key_valid rises next cycle.
REQ-027 Push while full and no pop SHALL drop the event and set overflow the next cycle; ovf_clr clears it; a set and a clear in the same cycle SHALL leave overflow set.
REQ-028 key_code SHALL be stable while key_valid && !key_ready.
REQ-029 Pointers SHALL be $clog2(FIFO_DEPTH)+1 bits and wrap naturally.

Reset
REQ-030 reset high SHALL asynchronously force: state SCAN, col 0, C = all ones except bit 0 low, synchronizer all ones, counters 0, FIFO empty, key_valid 0, key_code 0, key_held 0, overflow 0.
REQ-031 Reset mid-press SHALL discard the press; no event is generated for a key already held at release of reset until it passes full PRESS_DB.

Configuration
REQ-032 Macro KEYPAD_REPEAT_EN SHALL enable auto-repeat.
REQ-033 Defined: in HELD, a repeat counter pushes the same code every REPEAT_CYCLES cycles (first repeat REPEAT_CYCLES after the initial push); drops set overflow as in REQ-027.
REQ-034 Undefined: exactly one event per debounced press; repeat counter absent from netlist.

Verification
REQ-035 Scenario 1: ROWS=COLS=4, press row 2 while column 1 driven, stable 40 cycles -> single event key_code=6, key_held=1, key_valid within latency of REQ-025.
REQ-036 Scenario 2: bounce row 0 low/high every 3 cycles for 30 cycles with DEBOUNCE_CYCLES=10 -> no event; then stable -> exactly one event.
REQ-037 Scenario 3: FIFO_DEPTH=4, key_ready=0, five distinct presses -> key_valid=1, 4 codes in order, overflow=1; ovf_clr pulse -> overflow=0.
REQ-038 Scenario 4: rows 1 and 3 low together in column 2 -> key_code=9; release -> RELEASE_DB then SCAN at column 3.
REQ-039 Scenario 5: assert reset during PRESS_DB -> C=4'b1110, key_valid=0 asynchronously; no event until key re-debounced.
REQ-040 Scenario 6 (KEYPAD_REPEAT_EN, REPEAT_CYCLES=100): hold key 350 cycles past acceptance -> 1 initial + 3 repeat events of the same code.
